// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// then holds the result and flags until the consumer accepts them.
module chunked_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [KW-1:0]    k;
   logic             carry;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;

   logic [CHUNK-1:0] cur_a;
   logic [CHUNK-1:0] cur_b;
   logic [CHUNK:0]   chunk_res;
   logic [WIDTH-1:0] next_sum;
   logic             msb_cin;
   logic             last;

   function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                input logic [CHUNK-1:0] y,
                                                input logic             c);
      return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
   endfunction

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_comb begin
      cur_a     = opa[int'(k)*CHUNK +: CHUNK];
      cur_b     = opb[int'(k)*CHUNK +: CHUNK];
      chunk_res = chunk_add(cur_a, cur_b, carry);
      // carry into the MSB recovered from its sum bit and operand bits
      msb_cin   = cur_a[CHUNK-1] ^ cur_b[CHUNK-1] ^ chunk_res[CHUNK-1];
      next_sum  = sum;
      next_sum[int'(k)*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
      last      = (k == KW'(NCHUNK - 1));
   end

   // Captured operands need no reset: they are only read after a capture.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         opa <= a;
         opb <= sub ? ~b : b;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         k     <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         zero  <= 1'b0;
         neg   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  carry <= sub ? 1'b1 : cin;
                  k     <= '0;
                  sum   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum   <= next_sum;
               carry <= chunk_res[CHUNK];
               k     <= k + 1'b1;
               if (last) begin
                  cout  <= chunk_res[CHUNK];
                  ovf   <= msb_cin ^ chunk_res[CHUNK];
                  zero  <= (next_sum == '0);
                  neg   <= next_sum[WIDTH-1];
                  k     <= '0;
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder (WIDTH=16, CHUNK=4) with hand-computed
// expected results, latency, backpressure, reset abort and streaming.
module tb_chunked_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic        zero;
   logic        neg;

   int n_tests = 0;
   int n_fail  = 0;

   chunked_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
      .zero(zero), .neg(neg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one operation, scramble the inputs while it runs, check the result.
   task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic vs, input logic [15:0] esum,
                         input logic ec, input logic eo, input logic ez, input logic en);
      int lat;
      @(negedge clk);
      check({tag, ".ready"}, in_ready, 1'b1);
      a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
      @(posedge clk);
      lat = 0;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 20) begin
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         @(posedge clk); lat++;
         @(negedge clk);
      end
      check({tag, ".lat"}, lat, 4);
      check({tag, ".sum"}, sum, esum);
      check({tag, ".cout"}, cout, ec);
      check({tag, ".ovf"}, ovf, eo);
      check({tag, ".zero"}, zero, ez);
      check({tag, ".neg"}, neg, en);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, ".idle"}, {out_valid, in_ready}, 2'b01);
   endtask

   logic [15:0] sa [3];
   logic [15:0] sb [3];
   logic        ss [3];
   logic [15:0] se [3];

   initial begin
      int idx_in, idx_out, last_cyc;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.flags", {out_valid, in_ready, cout, ovf, zero, neg}, 6'b010000);
      check("rst.sum", sum, 16'h0000);
      rst_n = 1'b1;

      run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
      run_op("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
      run_op("wrapcin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
      run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
      run_op("cin_prop", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);

      // Backpressure: hold DONE for 3 cycles
      @(negedge clk);
      a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) begin
         a = 16'($urandom); b = 16'($urandom);
         @(posedge clk); @(negedge clk);
      end
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         check("bp.hs", {out_valid, in_ready}, 2'b10);
         check("bp.sum", sum, 16'h5555);
         check("bp.flags", {cout, ovf, zero, neg}, 4'b0000);
      end
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;

      // Reset during the 2nd RUN cycle, with in_valid held high across it
      a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      check("abort.hs", {out_valid, in_ready}, 2'b01);
      check("abort.sum", sum, 16'h0000);
      check("abort.flags", {cout, ovf, zero, neg}, 4'b0000);
      run_op("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);

      // Streaming: one result every NCHUNK+2 cycles
      sa[0] = 16'h0001; sb[0] = 16'h0002; ss[0] = 1'b0; se[0] = 16'h0003;
      sa[1] = 16'hABCD; sb[1] = 16'h1111; ss[1] = 1'b0; se[1] = 16'hBCDE;
      sa[2] = 16'h1000; sb[2] = 16'h0001; ss[2] = 1'b1; se[2] = 16'h0FFF;
      idx_in = 0; idx_out = 0; last_cyc = 0;
      out_ready = 1'b1;
      @(negedge clk);
      for (int cyc = 0; cyc < 60 && idx_out < 3; cyc++) begin
         if (out_valid) begin
            check($sformatf("b2b.sum%0d", idx_out), sum, se[idx_out]);
            if (idx_out > 0) check($sformatf("b2b.gap%0d", idx_out), cyc - last_cyc, 6);
            last_cyc = cyc;
            idx_out++;
         end
         if (in_ready) begin
            if (idx_in < 3) begin
               a = sa[idx_in]; b = sb[idx_in]; sub = ss[idx_in]; cin = 1'b0;
               in_valid = 1'b1;
               idx_in++;
            end else begin
               in_valid = 1'b0;
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      check("b2b.count", idx_out, 3);
      in_valid = 1'b0;
      out_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, default 4: bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK. NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous reset, active-low, sampled on rising clk edge.
REQ-005 in_valid  input  1  operand set present on a, b, cin, sub.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in for add mode; ignored when sub=1.
REQ-010 sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-015 ovf  output  1  signed two's-complement overflow.
REQ-016 zero  output  1  sum == 0.
REQ-017 neg  output  1  sum[WIDTH-1].

Function
REQ-018 FSM states IDLE, RUN, DONE; in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-019 IDLE: on edge with in_valid=1, SHALL capture a, b (b inverted if sub=1), carry = sub ? 1 : cin, clear chunk index and result register, go RUN; otherwise stay IDLE.
REQ-020 RUN: each edge SHALL add chunk k (bits k*CHUNK+CHUNK-1..k*CHUNK) of both captured operands plus carry register, write sum chunk k, update carry, increment k; LSB chunk first.
REQ-021 RUN SHALL last exactly NCHUNK edges; the edge processing chunk NCHUNK-1 SHALL move to DONE, so out_valid rises NCHUNK cycles after the accepting edge.
REQ-022 ovf SHALL be the XOR of the carry into bit WIDTH-1 and the carry out of bit WIDTH-1, captured during the final chunk.
REQ-023 DONE: sum, cout, ovf, zero, neg SHALL be held stable until an edge with out_ready=1, which SHALL return to IDLE; earliest next accept is the edge after.
REQ-024 Inputs a, b, cin, sub SHALL be ignored outside IDLE; changes during RUN/DONE SHALL not affect the result.
REQ-025 CHUNK == WIDTH SHALL be legal: RUN lasts one cycle.
REQ-026 sum, cout, ovf, zero, neg SHALL be registered outputs; in DONE they reflect only the last accepted operand set.

Reset
REQ-027 Edge with rst_n=0 SHALL force state IDLE, chunk index 0, carry 0, sum 0, cout 0, ovf 0, zero 0, neg 0, from any state including mid-RUN and DONE.
REQ-028 After reset, out_valid=0 and in_ready=1; an aborted operation SHALL produce no result.
REQ-029 in_valid=1 on an edge with rst_n=0 SHALL not be accepted.

Verification (WIDTH=16, CHUNK=4)
REQ-030 a=0x7FFF, b=0x0001, cin=0, sub=0 -> out_valid 4 cycles after accept, sum=0x8000, cout=0, ovf=1, zero=0, neg=1.
REQ-031 a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, zero=1, neg=0; a=0xFFFF, b=0x0000, cin=1 gives identical result.
REQ-032 a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0, neg=1; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-033 Backpressure: out_ready=0 for 3 cycles in DONE -> sum/flags stable, out_valid=1, in_ready=0; operands changed during RUN do not alter result.
REQ-034 rst_n=0 for one edge during 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0, all flags 0; following op a=0x1234, b=0x1111 -> sum=0x2345.
REQ-035 Back-to-back: out_ready held 1, in_valid held 1 with new operands -> one result per NCHUNK+2 cycles, each correct.
